// File: rtl/svm_rom_dma.sv
// ROM-to-FIFO read DMA: streams a word-aligned ROM range into the ROM data FIFO.
// Define SVM_ROM_DMA_SKID_EN for a 2-word buffer and full-rate streaming.
module svm_rom_dma #(
   parameter int ROM_ADDR_WIDTH = 16,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_rd,
   input  logic                      cfg_ready,
   input  logic [ROM_ADDR_WIDTH-1:0] cfg_dma_base_addr,
   input  logic [ROM_ADDR_WIDTH-1:0] cfg_dma_num_bytes,
   output logic                      batch_dma_done,
   output logic                      dma_busy,
   output logic                      rom_rd_en,
   output logic [ROM_ADDR_WIDTH-1:0] rom_rd_addr,
   input  logic [DATA_WIDTH-1:0]     rom_rd_data,
   output logic [DATA_WIDTH-1:0]     rom_data_fifo_fifo_data_in,
   output logic                      rom_data_fifo_fifo_data_push,
   input  logic                      rom_data_fifo_fifo_full
);

`ifdef SVM_ROM_DMA_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif
   localparam int W = ROM_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                state_q;
   logic [W-1:0]          addr_q;
   logic [W-1:0]          left_q;
   logic                  rd_pend_q;
   logic [1:0]            cnt_q;
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic [DATA_WIDTH-1:0] buf_q [2];
   logic [DATA_WIDTH-1:0] last_q;

   logic [W:0]            words;
   logic [2:0]            occ;
   logic [1:0]            cnt_d;
   logic                  push_fire;
   logic                  issue;
   logic                  fin;
   logic                  unused_ok;

   function automatic logic nxt_ptr(input logic p);
      return (DEPTH == 2) ? ~p : 1'b0;
   endfunction

   // Extra bit keeps num_bytes + 3 from wrapping near the top of the range.
   assign words = ({1'b0, cfg_dma_num_bytes} + (W+1)'(3)) >> 2;
   assign unused_ok = ^{cfg_dma_base_addr[1:0], words[W]};

   assign push_fire = (cnt_q != 2'd0) && !rom_data_fifo_fifo_full;
   assign occ = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, push_fire};
   assign issue = (state_q == RUN) && (left_q != '0) && (occ < 3'(DEPTH));
   assign cnt_d = cnt_q + {1'b0, rd_pend_q} - {1'b0, push_fire};
   // Leave RUN on the edge that empties the buffer so done follows the last push.
   assign fin = (left_q == '0) && !rd_pend_q && (cnt_d == 2'd0);

   assign rom_rd_en = issue;
   assign rom_rd_addr = addr_q;
   assign rom_data_fifo_fifo_data_push = push_fire;
   assign rom_data_fifo_fifo_data_in = (cnt_q != 2'd0) ? buf_q[rd_ptr_q] : last_q;
   assign batch_dma_done = (state_q == DONE);
   assign dma_busy = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         left_q    <= '0;
         rd_pend_q <= 1'b0;
         cnt_q     <= 2'd0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         buf_q[0]  <= '0;
         buf_q[1]  <= '0;
         last_q    <= '0;
      end else begin
         rd_pend_q <= issue;
         cnt_q     <= cnt_d;
         if (rd_pend_q) begin
            buf_q[wr_ptr_q] <= rom_rd_data;
            wr_ptr_q        <= nxt_ptr(wr_ptr_q);
         end
         if (push_fire) begin
            last_q   <= buf_q[rd_ptr_q];
            rd_ptr_q <= nxt_ptr(rd_ptr_q);
         end
         if (issue) begin
            addr_q <= addr_q + W'(4);
            left_q <= left_q - W'(1);
         end
         unique case (state_q)
            IDLE: begin
               if (start_rd && cfg_ready) begin
                  addr_q  <= {cfg_dma_base_addr[W-1:2], 2'b00};
                  left_q  <= words[W-1:0];
                  state_q <= (words != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (fin) state_q <= DONE;
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/svm_rom_dma.md
# svm_rom_dma

ROM-to-FIFO read DMA engine serving the SVM memory manager's DMA config interface. It accepts a base address and a byte count on `start_rd`, reads the ROM one 32-bit word at a time, and pushes each word into the memory manager's ROM data FIFO under `fifo_full` backpressure. It signals `batch_dma_done` when the batch completes, and sits between the ROM macro and `svm_mem_mngr` in the SVM core.

## Interface
- `ROM_ADDR_WIDTH`, 16, width of the byte address and byte count.
- `DATA_WIDTH`, 32, ROM and FIFO word width; fixed at 32, other values unsupported.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_rd` in 1: batch start request, single-cycle pulse.
- `cfg_ready` in 1: `cfg_dma_base_addr`/`cfg_dma_num_bytes` valid; qualifies `start_rd`.
- `cfg_dma_base_addr` in ROM_ADDR_WIDTH: byte address of first word; bits [1:0] ignored.
- `cfg_dma_num_bytes` in ROM_ADDR_WIDTH: batch length in bytes.
- `batch_dma_done` out 1: one-cycle pulse at batch end.
- `dma_busy` out 1: high from accepted start until the done pulse, inclusive.
- `rom_rd_en` out 1: ROM read strobe.
- `rom_rd_addr` out ROM_ADDR_WIDTH: ROM byte address, word aligned.
- `rom_rd_data` in 32: ROM read data, valid exactly 1 cycle after `rom_rd_en`.
- `rom_data_fifo_fifo_data_in` out 32: word to the FIFO.
- `rom_data_fifo_fifo_data_push` out 1: push strobe; never high while `rom_data_fifo_fifo_full` is high.
- `rom_data_fifo_fifo_full` in 1: FIFO full backpressure.

## Operation
- States:
  - IDLE: start accepted when `start_rd && cfg_ready`.
    - Latches `addr = {base[W-1:2],2'b00}` and `words = (num_bytes + 3) >> 2`, computed in W+1 bits so there is no overflow.
    - Goes to RUN if `words != 0`, else to DONE.
  - RUN: issues reads and drains the buffer. Moves to DONE when all words are issued, `rd_pend` is 0, and the buffer is empty.
  - DONE: `batch_dma_done = 1` for one cycle, then IDLE.
- `start_rd` outside IDLE is ignored; it is neither queued nor able to restart. `start_rd` without `cfg_ready` is ignored.
- Internal state:
  - Holding buffer of DEPTH words (see Configuration) with occupancy `cnt`.
  - `rd_pend` flags a read issued in the previous cycle.
  - `issue_left` counts words still to be issued.
- Read issue in cycle N: `issue_left != 0 && (cnt + rd_pend - push_fire) < DEPTH`.
  - `rom_rd_en = 1` and `rom_rd_addr = addr`.
  - `addr += 4`, wrapping mod 2^W.
  - `issue_left -= 1`.
- Data capture: when `rd_pend` is set, `rom_rd_data` is written into the buffer tail at the end of that cycle. The issue rule guarantees the buffer never overflows.
- Push: `push_fire = (cnt != 0) && !fifo_full`.
  - `data_in` = buffer head; words go out in ROM address order.
  - When `cnt == 0`, `data_in` holds its last value.
- No partial-word masking: a trailing partial word is pushed whole.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt = 0`, `rd_pend = 0`, counters 0. `data_in` resets to 0.
- Reset mid-batch: immediate return to IDLE. No done pulse. FIFO contents already pushed are not recalled.
- Latency, FIFO never full:
  - Start sampled at edge 0.
  - First `rom_rd_en` in cycle 1.
  - Data captured at end of cycle 2.
  - First push in cycle 3.
  - `batch_dma_done` in the cycle after the last push.
- Throughput: 1 word/cycle with DEPTH=2; 1 word per 2 cycles with DEPTH=1.
- Zero-length batch: `dma_busy` high in cycle 1, `batch_dma_done` in cycle 1, no reads.
- `fifo_full` asserted: pushes stall, and issue stops once `cnt + rd_pend` reaches DEPTH. No word is lost or duplicated.
- `fifo_full` deasserting: the push resumes in the same cycle full is low.
- Simultaneous push and capture in one cycle: `cnt` is unchanged.

## Configuration
- `SVM_ROM_DMA_SKID_EN` defined: DEPTH = 2, giving full one-word-per-cycle streaming.
- `SVM_ROM_DMA_SKID_EN` undefined: DEPTH = 1, a single holding register; reads issue only when the buffer is empty or being pushed and no read is pending. Throughput halves.
- Ordering, done timing and reset behaviour are identical in both builds.

## Test plan
- Basic batch: base=0x0100, bytes=16, FIFO never full, ROM returns addr-tagged words → 4 pushes of words at 0x100/0x104/0x108/0x10C in order. Done pulse 1 cycle after the 4th push; with SKID_EN, pushes land in cycles 3–6.
- Rounding and alignment: base=0x0203, bytes=5 → reads at 0x0200 and 0x0204 only, 2 pushes, 1 done pulse.
- Zero length: bytes=0 → no `rom_rd_en`, no push, done in cycle 1.
- Backpressure: bytes=32, `fifo_full` high for cycles 4–10 and every third cycle after → 8 pushes, in order, none while full. `cnt + rd_pend` never exceeds DEPTH.
- Start filtering: `start_rd` mid-batch, and `start_rd` with `cfg_ready=0` in IDLE → both ignored; the batch count is unchanged.
- Async reset at the 2nd push of an 8-word batch → outputs 0 immediately. A following batch with base=0x0000, bytes=8 completes normally with 2 pushes. Address wrap checked with base=0xFFFC, bytes=8: reads at 0xFFFC then 0x0000.
